// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Bit positions inside the packed m_MEM / wb_MEM control vectors.
    localparam int M_BRANCH      = 2;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 0;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } m_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic is_mem_op(input m_t m);
        return m.mem_read | m.mem_write;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: holds the bundle handed to the write-back stage.
// Latency: 1 cycle from ld to q_*.
// Backpressure: none; holds its contents while ld == 0, clr wins over ld.
//
// Ports: clk; clr (synchronous clear, all fields to 0); ld (load enable);
//        d_* next bundle (valid, load data, ALU result, dest reg, WB bits);
//        q_* registered bundle.
module mem_wb_reg
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_read_data,
    input  logic [DATA_W-1:0] d_alu_res,
    input  logic [4:0]        d_wr_reg,
    input  wb_t               d_wb,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_read_data,
    output logic [DATA_W-1:0] q_alu_res,
    output logic [4:0]        q_wr_reg,
    output wb_t               q_wb
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q_valid     <= 1'b0;
            q_read_data <= '0;
            q_alu_res   <= '0;
            q_wr_reg    <= '0;
            q_wb        <= '0;
        end else if (ld) begin
            q_valid     <= d_valid;
            q_read_data <= d_read_data;
            q_alu_res   <= d_alu_res;
            q_wr_reg    <= d_wr_reg;
            q_wb        <= d_wb;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory req/ack access FSM, MEM/WB register.
// Latency: 1 cycle for non-memory bundles; 2 cycles + ack wait cycles for loads/stores.
// Backpressure: stall held high while an access waits for dmem_ack.
//
// Ports: clk, reset (sync, active-high); EX bundle in (ex_valid, res, zero,
//        data_2, write_register, m_MEM, wb_MEM) plus flush; stall and pc_src
//        back to the front end; dmem_* req/ack memory port; MEM/WB bundle out
//        (wb_valid, read_data_WB, alu_res_WB, write_register_WB, wb_WB).
// Optional: MEM_ALIGN_CHECK_EN adds the sticky misalign output and suppresses
//        accesses whose address is not word aligned.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] res,
    input  logic              zero,
    input  logic [DATA_W-1:0] data_2,
    input  logic [4:0]        write_register,
    input  logic [2:0]        m_MEM,
    input  logic [1:0]        wb_MEM,
    input  logic              flush,
    output logic              stall,
    output logic              pc_src,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] read_data_WB,
    output logic [DATA_W-1:0] alu_res_WB,
    output logic [4:0]        write_register_WB,
    output logic [1:0]        wb_WB
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    // EX/MEM register
    logic              exm_valid;
    logic [DATA_W-1:0] exm_res;
    logic              exm_zero;
    logic [DATA_W-1:0] exm_data;
    logic [4:0]        exm_wr_reg;
    m_t                exm_m;
    wb_t               exm_wb;

    state_t state, state_nxt;

    logic mem_op;
    logic misaligned;
    logic launch;
    logic in_access;
    logic complete;
    logic exm_ld;

    // MEM/WB next-bundle signals
    logic              mw_ld;
    logic              mw_clr;
    logic [DATA_W-1:0] mw_read_data;
    wb_t               mw_wb;
    wb_t               wb_q;

    assign mem_op = is_mem_op(exm_m);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (exm_res[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign in_access = (state == ACCESS);
    assign complete  = in_access & dmem_ack;
    assign launch    = (state == IDLE) & exm_valid & mem_op & ~misaligned;
    assign stall     = in_access & ~dmem_ack;

    // The launching bundle must stay in EX/MEM for the whole access, so the
    // register also holds on the IDLE->ACCESS edge; it reopens on the ack edge.
    assign exm_ld = ~stall & ~launch;

    always_ff @(posedge clk) begin
        if (reset) begin
            exm_valid  <= 1'b0;
            exm_res    <= '0;
            exm_zero   <= 1'b0;
            exm_data   <= '0;
            exm_wr_reg <= '0;
            exm_m      <= '0;
            exm_wb     <= '0;
        end else begin
            if (exm_ld) begin
                exm_valid  <= ex_valid;
                exm_res    <= res;
                exm_zero   <= zero;
                exm_data   <= data_2;
                exm_wr_reg <= write_register;
                exm_m      <= '{branch:    m_MEM[M_BRANCH],
                                mem_read:  m_MEM[M_MEM_READ],
                                mem_write: m_MEM[M_MEM_WRITE]};
                exm_wb     <= '{reg_write:  wb_MEM[WB_REG_WRITE],
                                mem_to_reg: wb_MEM[WB_MEM_TO_REG]};
            end
            // A killed bundle keeps its fields so an in-flight access can
            // still drive the memory port to completion.
            if (flush) begin
                exm_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch)   state_nxt = ACCESS;
            ACCESS:  if (dmem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port: only meaningful in ACCESS, forced quiet otherwise.
    assign dmem_req   = in_access;
    assign dmem_we    = in_access & exm_m.mem_write;
    assign dmem_addr  = in_access ? exm_res[ADDR_W-1:0] : '0;
    assign dmem_wdata = in_access ? exm_data : '0;

    assign pc_src = exm_valid & exm_m.branch & exm_zero & ~in_access;

    // MEM/WB: written on access completion, or in IDLE for anything that does
    // not launch an access. An empty EX/MEM slot becomes a cleared bubble.
    assign mw_ld  = complete | ((state == IDLE) & ~launch);
    assign mw_clr = reset | ((state == IDLE) & ~exm_valid);

    // Read+write together behaves as a store, so nothing is loaded back.
    assign mw_read_data = (complete & exm_m.mem_read & ~exm_m.mem_write) ? dmem_rdata : '0;

    always_comb begin
        mw_wb = exm_wb;
        if (~exm_valid) begin
            mw_wb = '0;
        end else if (mem_op & ((exm_m.mem_read & exm_m.mem_write) | misaligned)) begin
            mw_wb = '0;
        end
    end

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk         (clk),
        .clr         (mw_clr),
        .ld          (mw_ld),
        .d_valid     (exm_valid),
        .d_read_data (mw_read_data),
        .d_alu_res   (exm_res),
        .d_wr_reg    (exm_wr_reg),
        .d_wb        (mw_wb),
        .q_valid     (wb_valid),
        .q_read_data (read_data_WB),
        .q_alu_res   (alu_res_WB),
        .q_wr_reg    (write_register_WB),
        .q_wb        (wb_q)
    );

    assign wb_WB = wb_q;

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if ((state == IDLE) & exm_valid & mem_op & misaligned) begin
            misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] res;
    logic        zero;
    logic [31:0] data_2;
    logic [4:0]  write_register;
    logic [2:0]  m_MEM;
    logic [1:0]  wb_MEM;
    logic        flush;
    logic        stall;
    logic        pc_src;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] read_data_WB;
    logic [31:0] alu_res_WB;
    logic [4:0]  write_register_WB;
    logic [1:0]  wb_WB;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .res               (res),
        .zero              (zero),
        .data_2            (data_2),
        .write_register    (write_register),
        .m_MEM             (m_MEM),
        .wb_MEM            (wb_MEM),
        .flush             (flush),
        .stall             (stall),
        .pc_src            (pc_src),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .wb_valid          (wb_valid),
        .read_data_WB      (read_data_WB),
        .alu_res_WB        (alu_res_WB),
        .write_register_WB (write_register_WB),
        .wb_WB             (wb_WB)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign          (misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] r,
                         input logic [31:0] d2, input logic [4:0] wr, input logic z);
        ex_valid       = 1'b1;
        m_MEM          = m;
        wb_MEM         = wb;
        res            = r;
        data_2         = d2;
        write_register = wr;
        zero           = z;
    endtask

    // One bundle through the stage with no overlap. The expectations come
    // straight from the stage's rules: non-memory ops retire one cycle after
    // EX/MEM capture, memory ops hold the port for waits+1 cycles, a flush
    // during the access retires an invalid bundle, read+write acts as a store.
    task automatic run_txn(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] r,
                           input logic [31:0] d2, input logic [4:0] wr, input logic z,
                           input int waits, input logic [31:0] rd, input bit do_flush);
        bit          is_mem;
        bit          exp_valid;
        logic [1:0]  exp_wb;
        logic [31:0] exp_rd;
        int          stall_cycles;
        is_mem    = m[1] | m[0];
        exp_valid = !(is_mem && do_flush && waits > 0);
        exp_wb    = (!exp_valid || (m[1] && m[0])) ? 2'b00 : wb;
        exp_rd    = (is_mem && m[1] && !m[0]) ? rd : 32'h0;
        stall_cycles = 0;

        @(negedge clk);
        drive(m, wb, r, d2, wr, z);
        @(negedge clk);
        ex_valid = 1'b0;
        check("pc_src_after_capture", 32'(pc_src), 32'(m[2] & z));
        check("stall_after_capture", 32'(stall), 32'h0);
        if (is_mem) begin
            check("req_in_launch_cycle", 32'(dmem_req), 32'h0);
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                flush = (do_flush && w == 0 && waits > 0);
                if (w == waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rd;
                end
                #1;
                if (stall) stall_cycles++;
                check("dmem_req", 32'(dmem_req), 32'h1);
                check("dmem_we", 32'(dmem_we), 32'(m[0]));
                check("dmem_addr", dmem_addr, r);
                check("dmem_wdata", dmem_wdata, d2);
                check("pc_src_in_access", 32'(pc_src), 32'h0);
            end
            check("stall_cycle_count", 32'(stall_cycles), 32'(waits));
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        flush      = 1'b0;
        dmem_rdata = $urandom;
        check("wb_valid", 32'(wb_valid), 32'(exp_valid));
        check("wb_WB", 32'(wb_WB), 32'(exp_wb));
        if (exp_valid) begin
            check("alu_res_WB", alu_res_WB, r);
            check("write_register_WB", 32'(write_register_WB), 32'(wr));
            check("read_data_WB", read_data_WB, exp_rd);
        end
        check("req_after_completion", 32'(dmem_req), 32'h0);
        @(negedge clk);
        check("wb_valid_bubble", 32'(wb_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_valid = 1'b0; res = '0; zero = 1'b0; data_2 = '0;
        write_register = '0; m_MEM = '0; wb_MEM = '0; flush = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_pc_src", 32'(pc_src), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_wb_WB", 32'(wb_WB), 32'h0);
        check("rst_alu_res_WB", alu_res_WB, 32'h0);
        reset = 1'b0;

        // ALU op, load with 3 wait cycles, store with immediate ack.
        run_txn(3'b000, 2'b10, 32'h0000_0010, 32'h0, 5'd5, 1'b0, 0, 32'h0, 1'b0);
        run_txn(3'b010, 2'b11, 32'h0000_0100, 32'h0, 5'd7, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        run_txn(3'b001, 2'b00, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b0, 0, 32'h0, 1'b0);
        // Read and write together: a store, WB bits forced off.
        run_txn(3'b011, 2'b11, 32'h0000_0300, 32'h1234_5678, 5'd9, 1'b0, 1, 32'h5555_AAAA, 1'b0);

        // Branch followed back-to-back by a load that is flushed mid-access.
        @(negedge clk);
        drive(3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        check("branch_pc_src", 32'(pc_src), 32'h1);
        drive(3'b010, 2'b11, 32'h0000_0400, 32'h0, 5'd12, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        check("branch_pc_src_one_cycle", 32'(pc_src), 32'h0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_load_req", 32'(dmem_req), 32'h1);
        @(negedge clk);
        flush = 1'b0;
        check("flush_load_still_req", 32'(dmem_req), 32'h1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("flush_load_wb_valid", 32'(wb_valid), 32'h0);
        check("flush_load_wb_WB", 32'(wb_WB), 32'h0);
        check("flush_load_req_dropped", 32'(dmem_req), 32'h0);
        @(negedge clk);

        // A bundle waiting upstream enters EX/MEM on the ack edge.
        @(negedge clk);
        drive(3'b010, 2'b11, 32'h0000_0040, 32'h0, 5'd3, 1'b0);
        @(negedge clk);
        drive(3'b000, 2'b10, 32'h0000_0077, 32'h0, 5'd9, 1'b0);
        @(negedge clk);
        check("overlap_stall", 32'(stall), 32'h1);
        @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_1234;
        @(negedge clk);
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        check("overlap_load_valid", 32'(wb_valid), 32'h1);
        check("overlap_load_data", read_data_WB, 32'h0000_1234);
        check("overlap_load_reg", 32'(write_register_WB), 32'd3);
        @(negedge clk);
        check("overlap_alu_valid", 32'(wb_valid), 32'h1);
        check("overlap_alu_res", alu_res_WB, 32'h0000_0077);
        check("overlap_alu_reg", 32'(write_register_WB), 32'd9);
        check("overlap_alu_rdata", read_data_WB, 32'h0);
        @(negedge clk);

        // Reset on the second wait cycle of a load.
        @(negedge clk);
        drive(3'b010, 2'b11, 32'h0000_0500, 32'h0, 5'd4, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_req", 32'(dmem_req), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_req", 32'(dmem_req), 32'h0);
        check("reset_mid_stall", 32'(stall), 32'h0);
        check("reset_mid_wb_valid", 32'(wb_valid), 32'h0);
        @(negedge clk);

        // Random bundles against the rule-level expectations in run_txn.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] m;
            case ($urandom_range(0, 4))
                0:       m = 3'b000;
                1:       m = 3'b010;
                2:       m = 3'b001;
                3:       m = 3'b011;
                default: m = 3'b100;
            endcase
            run_txn(m, 2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
        end

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        drive(3'b010, 2'b11, 32'h0000_0102, 32'h0, 5'd6, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        check("misalign_no_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        check("misalign_still_no_req", 32'(dmem_req), 32'h0);
        check("misalign_flag", 32'(misalign), 32'h1);
        check("misalign_wb_valid", 32'(wb_valid), 32'h1);
        check("misalign_wb_WB", 32'(wb_WB), 32'h0);
        @(negedge clk);
        check("misalign_sticky", 32'(misalign), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
